// File: rtl/joystick_tx.sv
// Joystick sample UART transmitter: sends vx_i or vy_i as one 8N1 frame
// on every edge of the asynchronous sel_i request line.
module joystick_tx #(
    parameter int CLK_HZ = 100000000,
    parameter int BAUD   = 9600
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] vx_i,
    input  logic [7:0] vy_i,
    input  logic       sel_i,
    output logic       tx_o,
    output logic       busy_o,
    output logic       done_o
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             sync1_q, sync2_q, prev_q;
    logic             req_q, req_d;
    logic             req_sel_q, req_sel_d;
    logic             sel_edge;
    logic             bit_end;
    logic             take;

    assign sel_edge = sync2_q ^ prev_q;
    assign bit_end  = (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        take    = 1'b0;
        tx_o    = 1'b1;
        busy_o  = 1'b1;
        done_o  = 1'b0;
        unique case (state_q)
            IDLE: begin
                busy_o = 1'b0;
                cnt_d  = '0;
                take   = req_q;
            end
            START: begin
                tx_o = 1'b0;
                if (bit_end) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                tx_o = shreg_q[0];
                if (bit_end) begin
                    cnt_d   = '0;
                    shreg_d = {1'b0, shreg_q[7:1]};
                    if (idx_q == 3'd7) state_d = STOP;
                    else               idx_d   = idx_q + 3'd1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    done_o  = 1'b1;
                    cnt_d   = '0;
                    take    = req_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Serving a request starts a frame with no idle gap
        if (take) begin
            state_d = START;
            cnt_d   = '0;
            idx_d   = '0;
            shreg_d = req_sel_q ? vy_i : vx_i;
        end
    end

    // A fresh edge wins over consumption so it is never dropped
    always_comb begin
        req_d     = req_q;
        req_sel_d = req_sel_q;
        if (take) req_d = 1'b0;
        if (sel_edge) begin
            req_d     = 1'b1;
            req_sel_d = sync2_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            shreg_q   <= '0;
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            prev_q    <= 1'b0;
            req_q     <= 1'b0;
            req_sel_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shreg_q   <= shreg_d;
            sync1_q   <= sel_i;
            sync2_q   <= sync1_q;
            prev_q    <= sync2_q;
            req_q     <= req_d;
            req_sel_q <= req_sel_d;
        end
    end

endmodule

// File: tb/tb_joystick_tx.sv
// Self-checking bench for joystick_tx: frames decoded from tx_o and
// compared against a scoreboard of expected bytes.
module tb_joystick_tx;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic [7:0] vx_i  = 8'h00;
    logic [7:0] vy_i  = 8'h00;
    logic       sel_i = 1'b0;
    logic       tx_o;
    logic       busy_o;
    logic       done_o;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] sb[$];
    logic [7:0] exp_b;

    bit         c_ok;
    logic [7:0] c_data;
    int         c_lat, c_done_k, c_done_n, c_busy_n, c_glitch;

    joystick_tx #(.CLK_HZ(1000), .BAUD(100)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .vx_i  (vx_i),
        .vy_i  (vy_i),
        .sel_i (sel_i),
        .tx_o  (tx_o),
        .busy_o(busy_o),
        .done_o(done_o)
    );

    always #5 clk_i = ~clk_i;

    // Waits (bounded) for a start bit, then records one 100-clock frame
    task automatic capture(input int timeout);
        int b, off;
        logic first;
        c_ok = 1'b0; c_data = 'x; c_lat = 0;
        c_done_k = 0; c_done_n = 0; c_busy_n = 0; c_glitch = 0;
        first = 1'b0;
        while (c_lat < timeout) begin
            @(negedge clk_i);
            c_lat++;
            if (tx_o === 1'b0) begin
                c_ok = 1'b1;
                break;
            end
        end
        if (!c_ok) return;
        for (int k = 1; k <= 100; k++) begin
            if (k > 1) @(negedge clk_i);
            b   = (k - 1) / 10;
            off = (k - 1) % 10;
            if (off == 0) first = tx_o;
            else if (tx_o !== first) c_glitch++;
            if (b == 0 && tx_o !== 1'b0) c_glitch++;
            if (b == 9 && tx_o !== 1'b1) c_glitch++;
            if (off == 5 && b >= 1 && b <= 8) c_data[b-1] = tx_o;
            if (busy_o === 1'b1) c_busy_n++;
            if (done_o === 1'b1) begin
                c_done_n++;
                c_done_k = k;
            end
        end
    endtask

    task automatic pop_exp();
        if (sb.size() > 0) exp_b = sb.pop_front();
        else exp_b = 'x;
    endtask

    task automatic test_reset();
        int act;
        #3;
        n_cmp++;
        if (tx_o !== 1'b1) begin
            n_bad++; $display("FAIL reset_tx got %b want 1", tx_o);
        end
        n_cmp++;
        if (busy_o !== 1'b0) begin
            n_bad++; $display("FAIL reset_busy got %b want 0", busy_o);
        end
        n_cmp++;
        if (done_o !== 1'b0) begin
            n_bad++; $display("FAIL reset_done got %b want 0", done_o);
        end
        repeat (3) @(negedge clk_i);
        rst_i = 1'b1;
        act = 0;
        repeat (30) begin
            @(negedge clk_i);
            if (tx_o !== 1'b1 || busy_o !== 1'b0) act++;
        end
        n_cmp++;
        if (act != 0) begin
            n_bad++; $display("FAIL reset_idle active_clocks %0d want 0", act);
        end
    endtask

    task automatic test_y();
        @(negedge clk_i);
        vy_i = 8'h3C;
        sel_i = 1'b1;
        sb.push_back(8'h3C);
        capture(20);
        pop_exp();
        n_cmp++;
        if (!c_ok || c_data !== exp_b) begin
            n_bad++; $display("FAIL y_frame got %h want %h", c_data, exp_b);
        end
        n_cmp++;
        if (c_glitch != 0) begin
            n_bad++; $display("FAIL y_shape bad_clocks %0d want 0", c_glitch);
        end
    endtask

    task automatic test_x();
        @(negedge clk_i);
        vx_i = 8'hA5;
        sel_i = 1'b0;
        sb.push_back(8'hA5);
        capture(20);
        pop_exp();
        n_cmp++;
        if (!c_ok || c_lat < 3 || c_lat > 4) begin
            n_bad++; $display("FAIL x_latency got %0d want 3..4", c_lat);
        end
        n_cmp++;
        if (c_data !== exp_b) begin
            n_bad++; $display("FAIL x_frame got %h want %h", c_data, exp_b);
        end
        n_cmp++;
        if (c_glitch != 0) begin
            n_bad++; $display("FAIL x_shape bad_clocks %0d want 0", c_glitch);
        end
        n_cmp++;
        if (c_done_k != 100 || c_done_n != 1) begin
            n_bad++;
            $display("FAIL x_done at %0d count %0d want 100/1", c_done_k, c_done_n);
        end
        n_cmp++;
        if (c_busy_n != 100) begin
            n_bad++; $display("FAIL x_busy got %0d want 100", c_busy_n);
        end
        @(negedge clk_i);
        n_cmp++;
        if (busy_o !== 1'b0 || tx_o !== 1'b1) begin
            n_bad++; $display("FAIL x_after busy %b tx %b want 0/1", busy_o, tx_o);
        end
    endtask

    task automatic test_back_to_back();
        int act;
        @(negedge clk_i);
        vy_i = 8'h5A;
        vx_i = 8'hC3;
        sel_i = 1'b1;
        sb.push_back(8'h5A);
        fork
            capture(20);
            begin
                repeat (30) @(negedge clk_i);
                sel_i = 1'b0;
                repeat (5) @(negedge clk_i);
                sel_i = 1'b1;
                repeat (5) @(negedge clk_i);
                sel_i = 1'b0;
                sb.push_back(8'hC3);
            end
        join
        pop_exp();
        n_cmp++;
        if (!c_ok || c_data !== exp_b) begin
            n_bad++; $display("FAIL b2b_first got %h want %h", c_data, exp_b);
        end
        n_cmp++;
        if (c_done_k != 100) begin
            n_bad++; $display("FAIL b2b_done at %0d want 100", c_done_k);
        end
        capture(20);
        pop_exp();
        n_cmp++;
        if (c_lat != 1) begin
            n_bad++; $display("FAIL b2b_gap got %0d want 1", c_lat);
        end
        n_cmp++;
        if (!c_ok || c_data !== exp_b) begin
            n_bad++; $display("FAIL b2b_second got %h want %h", c_data, exp_b);
        end
        act = 0;
        repeat (150) begin
            @(negedge clk_i);
            if (tx_o !== 1'b1 || busy_o !== 1'b0) act++;
        end
        n_cmp++;
        if (act != 0) begin
            n_bad++; $display("FAIL b2b_extra active_clocks %0d want 0", act);
        end
    endtask

    task automatic test_latch();
        @(negedge clk_i);
        vy_i = 8'h77;
        sel_i = 1'b1;
        sb.push_back(8'h77);
        capture(20);
        pop_exp();
        n_cmp++;
        if (!c_ok || c_data !== exp_b) begin
            n_bad++; $display("FAIL latch_pre got %h want %h", c_data, exp_b);
        end
        @(negedge clk_i);
        vx_i = 8'h00;
        sel_i = 1'b0;
        sb.push_back(8'h00);
        fork
            capture(20);
            begin
                repeat (10) @(negedge clk_i);
                vx_i = 8'hFF;
            end
        join
        pop_exp();
        n_cmp++;
        if (!c_ok || c_data !== exp_b) begin
            n_bad++; $display("FAIL latch_hold got %h want %h", c_data, exp_b);
        end
    endtask

    task automatic test_reset_mid();
        int w, act, dn;
        bit seen;
        @(negedge clk_i);
        vy_i = 8'h96;
        sel_i = 1'b1;
        seen = 1'b0;
        w = 0;
        while (w < 20 && !seen) begin
            @(negedge clk_i);
            w++;
            if (tx_o === 1'b0) seen = 1'b1;
        end
        n_cmp++;
        if (!seen) begin
            n_bad++; $display("FAIL rmid_start got none want start bit");
        end
        repeat (54) @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        n_cmp++;
        if (tx_o !== 1'b1 || busy_o !== 1'b0) begin
            n_bad++; $display("FAIL rmid_abort tx %b busy %b want 1/0", tx_o, busy_o);
        end
        dn = 0;
        sel_i = 1'b0;
        repeat (5) begin
            @(negedge clk_i);
            if (done_o !== 1'b0) dn++;
        end
        rst_i = 1'b1;
        act = 0;
        repeat (150) begin
            @(negedge clk_i);
            if (tx_o !== 1'b1 || busy_o !== 1'b0) act++;
            if (done_o !== 1'b0) dn++;
        end
        n_cmp++;
        if (dn != 0) begin
            n_bad++; $display("FAIL rmid_done got %0d pulses want 0", dn);
        end
        n_cmp++;
        if (act != 0) begin
            n_bad++; $display("FAIL rmid_quiet active_clocks %0d want 0", act);
        end
        @(negedge clk_i);
        sel_i = 1'b1;
        sb.push_back(8'h96);
        capture(20);
        pop_exp();
        n_cmp++;
        if (!c_ok || c_data !== exp_b) begin
            n_bad++; $display("FAIL rmid_resume got %h want %h", c_data, exp_b);
        end
    endtask

    task automatic test_sel_high_reset();
        int act;
        @(negedge clk_i);
        rst_i = 1'b0;
        sel_i = 1'b1;
        vy_i = 8'hE7;
        vx_i = 8'h11;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b1;
        sb.push_back(8'hE7);
        capture(20);
        pop_exp();
        n_cmp++;
        if (!c_ok || c_data !== exp_b) begin
            n_bad++; $display("FAIL selhigh_frame got %h want %h", c_data, exp_b);
        end
        act = 0;
        repeat (150) begin
            @(negedge clk_i);
            if (tx_o !== 1'b1 || busy_o !== 1'b0) act++;
        end
        n_cmp++;
        if (act != 0) begin
            n_bad++; $display("FAIL selhigh_once active_clocks %0d want 0", act);
        end
    endtask

    initial begin
        test_reset();
        test_y();
        test_x();
        test_back_to_back();
        test_latch();
        test_reset_mid();
        test_sel_high_reset();
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++; $display("FAIL sb_leftover got %0d want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
